// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the combinational ALU.
// Holds one operation on the ALU inputs for a fixed settle time, then
// captures the result and presents it downstream with valid/ready.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | ready for a request; alu_oprn parked at 0
//  EXEC  | alu_* held stable, settle counter running down to 0
//  DONE  | response presented; alu_* and rsp_* frozen until accepted
module alu_issue_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int OPRN_WIDTH  = 6,
    parameter int EXEC_CYCLES = 1,
    parameter int MUL_CYCLES  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [DATA_WIDTH-1:0] i_req_op1,
    input  logic [DATA_WIDTH-1:0] i_req_op2,
    input  logic [OPRN_WIDTH-1:0] i_req_oprn,
    output logic [DATA_WIDTH-1:0] o_alu_op1,
    output logic [DATA_WIDTH-1:0] o_alu_op2,
    output logic [OPRN_WIDTH-1:0] o_alu_oprn,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_result,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    // The counter is loaded with (settle - 1), so it only needs to hold max-1.
    localparam int CNT_MAX = (MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_alu_op1;
    logic [DATA_WIDTH-1:0] r_alu_op2;
    logic [OPRN_WIDTH-1:0] r_alu_oprn;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_zero;
    logic                  r_rsp_err;

    logic w_op_legal;
    logic w_is_mul;
    logic w_settle_done;

    // Opcodes 0x01..0x09 are the only ones the ALU defines.
    assign w_op_legal    = (i_req_oprn != '0) && (i_req_oprn <= OPRN_WIDTH'(9));
    assign w_is_mul      = (i_req_oprn == OPRN_WIDTH'(3));
    assign w_settle_done = (r_cnt == '0);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_req_valid) begin
                    w_state_nxt = w_op_legal ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                if (w_settle_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand/opcode hold registers, settle counter and response capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_oprn   <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (w_op_legal) begin
                            r_alu_op1  <= i_req_op1;
                            r_alu_op2  <= i_req_op2;
                            r_alu_oprn <= i_req_oprn;
                            r_cnt      <= w_is_mul ? CNT_W'(MUL_CYCLES - 1)
                                                   : CNT_W'(EXEC_CYCLES - 1);
                        end else begin
                            // Never issued: the ALU keeps seeing opcode 0.
                            r_alu_oprn   <= '0;
                            r_rsp_result <= '0;
                            r_rsp_zero   <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_settle_done) begin
                        r_rsp_result <= i_alu_result;
                        r_rsp_zero   <= (i_alu_result == '0);
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_rsp_ready) begin
                        r_alu_oprn <= '0;
                    end
                end
                default: begin
                    r_alu_oprn <= '0;
                end
            endcase
        end
    end

    assign o_alu_op1    = r_alu_op1;
    assign o_alu_op2    = r_alu_op2;
    assign o_alu_oprn   = r_alu_oprn;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_err    = r_rsp_err;

endmodule
